// File: rtl/btb_update_arb.sv
// btb_update_arb: merges branch-resolution updates from two requesters into a
// single BTB write port. Each requester owns a small FIFO; heads are granted
// round-robin and written one per cycle through registered outputs.
// Optional feature macro: BTB_INVAL_EN adds a drain-then-sweep invalidate
// sequence (RUN -> DRAIN -> SWEEP -> RUN) driven by inval_req.
module btb_update_arb #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned NENT  = 4
) (
   input  logic                    CLK,
   input  logic                    nRST,
   input  logic [1:0]              upd_valid,
   output logic [1:0]              upd_ready,
   input  logic [31:0]             upd_pc0,
   input  logic [31:0]             upd_pc1,
   input  logic [31:0]             upd_target0,
   input  logic [31:0]             upd_target1,
   input  logic [1:0]              upd_taken,
   output logic                    WEN,
   output logic [31:0]             pc_w,
   output logic [31:0]             target_w,
   output logic                    taken_w,
   input  logic                    inval_req,
   output logic                    inv_en,
   output logic [$clog2(NENT)-1:0] inv_idx,
   output logic                    busy
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned IW = $clog2(NENT);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_SWEEP = 2'd2;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        taken;
   } upd_t;

   upd_t          mem_q    [2][DEPTH];
   upd_t          in_c     [2];
   logic [PW-1:0] wr_ptr_q [2];
   logic [PW-1:0] wr_ptr_d [2];
   logic [PW-1:0] rd_ptr_q [2];
   logic [PW-1:0] rd_ptr_d [2];
   logic [CW-1:0] cnt_q    [2];
   logic [CW-1:0] cnt_d    [2];
   logic [1:0]    state_q, state_d;
   logic          last_q, last_d;
   logic          wen_q, wen_d;
   upd_t          wr_q, wr_d;
   upd_t          head;
   logic [1:0]    push, pop, nonempty, full;
   logic          grant;

   // Input payload packing and per-FIFO status
   always_comb begin
      in_c[0] = '{pc: upd_pc0, target: upd_target0, taken: upd_taken[0]};
      in_c[1] = '{pc: upd_pc1, target: upd_target1, taken: upd_taken[1]};
      nonempty = '0;
      full     = '0;
      for (int r = 0; r < 2; r++) begin
         nonempty[r] = (cnt_q[r] != '0);
         full[r]     = (cnt_q[r] == CW'(DEPTH));
      end
   end

   // Accept only in RUN with room; forced low while reset is asserted
   always_comb begin
      upd_ready = '0;
      if (nRST && (state_q == S_RUN)) upd_ready = ~full;
   end

   // Round-robin grant, pointer/occupancy next-state and write payload
   always_comb begin
      push  = upd_valid & upd_ready;
      pop   = '0;
      grant = 1'b0;
      if ((state_q != S_SWEEP) && (|nonempty)) begin
         grant      = (&nonempty) ? ~last_q : nonempty[1];
         pop[grant] = 1'b1;
      end
      head   = mem_q[grant][rd_ptr_q[grant]];
      last_d = (|pop) ? grant : last_q;
      wen_d  = |pop;
      wr_d   = (|pop) ? head : wr_q;
      for (int r = 0; r < 2; r++) begin
         wr_ptr_d[r] = wr_ptr_q[r] + PW'(push[r]);
         rd_ptr_d[r] = rd_ptr_q[r] + PW'(pop[r]);
         cnt_d[r]    = cnt_q[r] + CW'(push[r]) - CW'(pop[r]);
      end
   end

   // FIFO storage; contents need no reset since occupancy gates every read
   always_ff @(posedge CLK) begin
      for (int r = 0; r < 2; r++) begin
         if (push[r]) mem_q[r][wr_ptr_q[r]] <= in_c[r];
      end
   end

   // Control and output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int r = 0; r < 2; r++) begin
            wr_ptr_q[r] <= '0;
            rd_ptr_q[r] <= '0;
            cnt_q[r]    <= '0;
         end
         state_q <= S_RUN;
         last_q  <= 1'b1;
         wen_q   <= 1'b0;
         wr_q    <= '0;
      end else begin
         for (int r = 0; r < 2; r++) begin
            wr_ptr_q[r] <= wr_ptr_d[r];
            rd_ptr_q[r] <= rd_ptr_d[r];
            cnt_q[r]    <= cnt_d[r];
         end
         state_q <= state_d;
         last_q  <= last_d;
         wen_q   <= wen_d;
         wr_q    <= wr_d;
      end
   end

   assign WEN      = wen_q;
   assign pc_w     = wr_q.pc;
   assign target_w = wr_q.target;
   assign taken_w  = wr_q.taken;

`ifdef BTB_INVAL_EN
   localparam logic [1:0] S_DRAIN = 2'd1;

   logic [IW-1:0] idx_q, idx_d;
   logic          inv_en_q, inv_en_d;
   logic          busy_q, busy_d;

   // Invalidate sequencing: wait for both FIFOs to empty, then sweep every entry
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      inv_en_d = 1'b0;
      case (state_q)
         S_RUN: begin
            if (inval_req) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (!(|nonempty)) begin
               state_d  = S_SWEEP;
               idx_d    = '0;
               inv_en_d = 1'b1;
            end
         end
         S_SWEEP: begin
            if (idx_q == IW'(NENT - 1)) begin
               state_d = S_RUN;
               idx_d   = '0;
            end else begin
               idx_d    = idx_q + IW'(1);
               inv_en_d = 1'b1;
            end
         end
         default: state_d = S_RUN;
      endcase
      busy_d = (state_d != S_RUN);
   end

   // Sweep output registers
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         idx_q    <= '0;
         inv_en_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         idx_q    <= idx_d;
         inv_en_q <= inv_en_d;
         busy_q   <= busy_d;
      end
   end

   assign inv_en  = inv_en_q;
   assign inv_idx = idx_q;
   assign busy    = busy_q;
`else
   logic unused_inval;

   // Without the invalidate feature the arbiter never leaves RUN
   always_comb begin
      state_d = state_q;
   end

   assign unused_inval = inval_req;
   assign inv_en       = 1'b0;
   assign inv_idx      = '0;
   assign busy         = 1'b0;
`endif

endmodule

// File: tb/tb_btb_update_arb.sv
// tb_btb_update_arb: randomized scoreboard bench for btb_update_arb.
// The reference model keeps one queue per requester plus an expected-write
// queue; a negedge monitor pops and compares whenever the DUT presents WEN.
module tb_btb_update_arb;

   localparam int DEP  = 2;
   localparam int NENT = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] tg;
      logic        tk;
   } ent_t;

   logic        CLK = 1'b0;
   logic        nRST = 1'b0;
   logic [1:0]  upd_valid = '0;
   logic [1:0]  upd_ready;
   logic [31:0] upd_pc0 = '0, upd_pc1 = '0, upd_target0 = '0, upd_target1 = '0;
   logic [1:0]  upd_taken = '0;
   logic        WEN;
   logic [31:0] pc_w, target_w;
   logic        taken_w;
   logic        inval_req = 1'b0;
   logic        inv_en;
   logic [1:0]  inv_idx;
   logic        busy;

   int n_vec = 0;
   int n_err = 0;

   // Reference model state: mode 0=normal, 1=draining, 2=sweeping
   ent_t mq0[$];
   ent_t mq1[$];
   ent_t expq[$];
   int   m_last;
   int   m_mode;
   int   m_sidx;
   bit   m_r0, m_r1, m_e0, m_e1;
   int   m_g;
   ent_t m_ent;
   ent_t mon_ent;
   logic [1:0] exp_ready;

   btb_update_arb #(.DEPTH(DEP), .NENT(NENT)) dut (
      .CLK(CLK), .nRST(nRST),
      .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_pc0(upd_pc0), .upd_pc1(upd_pc1),
      .upd_target0(upd_target0), .upd_target1(upd_target1),
      .upd_taken(upd_taken),
      .WEN(WEN), .pc_w(pc_w), .target_w(target_w), .taken_w(taken_w),
      .inval_req(inval_req), .inv_en(inv_en), .inv_idx(inv_idx), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Reference model: one pop per edge from the older-waiting requester, then accept pushes
   always @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         mq0.delete();
         mq1.delete();
         expq.delete();
         m_last = 1;
         m_mode = 0;
         m_sidx = 0;
      end else begin
         m_e0 = (mq0.size() == 0);
         m_e1 = (mq1.size() == 0);
         m_r0 = (m_mode == 0) && (mq0.size() < DEP);
         m_r1 = (m_mode == 0) && (mq1.size() < DEP);
         m_g  = -1;
         if (m_mode != 2) begin
            if (!m_e0 && !m_e1) m_g = (m_last == 0) ? 1 : 0;
            else if (!m_e0)     m_g = 0;
            else if (!m_e1)     m_g = 1;
         end
         if (m_g == 0) begin
            m_ent = mq0.pop_front();
            expq.push_back(m_ent);
         end else if (m_g == 1) begin
            m_ent = mq1.pop_front();
            expq.push_back(m_ent);
         end
         if (m_g >= 0) m_last = m_g;
         if (upd_valid[0] && m_r0) mq0.push_back('{upd_pc0, upd_target0, upd_taken[0]});
         if (upd_valid[1] && m_r1) mq1.push_back('{upd_pc1, upd_target1, upd_taken[1]});
`ifdef BTB_INVAL_EN
         case (m_mode)
            0: if (inval_req) m_mode = 1;
            1: if (m_e0 && m_e1) begin
                  m_mode = 2;
                  m_sidx = 0;
               end
            default: begin
               if (m_sidx == NENT - 1) begin
                  m_mode = 0;
                  m_sidx = 0;
               end else begin
                  m_sidx = m_sidx + 1;
               end
            end
         endcase
`endif
      end
   end

   // Monitor: compare status every cycle, pop the scoreboard whenever WEN is seen
   always @(negedge CLK) begin
      exp_ready[0] = nRST && (m_mode == 0) && (mq0.size() < DEP);
      exp_ready[1] = nRST && (m_mode == 0) && (mq1.size() < DEP);
      chk("upd_ready", 96'(upd_ready), 96'(exp_ready));
      chk("wen", 96'(WEN), 96'(expq.size() != 0));
      if (WEN && (expq.size() != 0)) begin
         mon_ent = expq.pop_front();
         chk("write_payload", 96'({pc_w, target_w, taken_w}), 96'(mon_ent));
      end else if (!WEN) begin
         expq.delete();
      end
      chk("busy", 96'(busy), 96'(m_mode != 0));
      chk("inv_en", 96'(inv_en), 96'(m_mode == 2));
      chk("inv_idx", 96'(inv_idx), 96'((m_mode == 2) ? m_sidx : 0));
   end

   task automatic push1(input int r, input logic [31:0] pc, input logic [31:0] tg, input logic tk);
      upd_valid = '0;
      upd_valid[r] = 1'b1;
      if (r == 0) begin
         upd_pc0 = pc; upd_target0 = tg; upd_taken[0] = tk;
      end else begin
         upd_pc1 = pc; upd_target1 = tg; upd_taken[1] = tk;
      end
      step();
      upd_valid = '0;
   endtask

   initial begin
      repeat (3) step();
      chk("rst_ready", 96'(upd_ready), 96'(0));
      chk("rst_pc_w", 96'({pc_w, target_w, taken_w}), 96'(0));
      nRST = 1'b1;
      step();

      // Both requesters push on every edge; r0 should win the first tie
      for (int i = 0; i < 8; i++) begin
         upd_valid   = 2'b11;
         upd_pc0     = 32'h1000 + 32'(i * 4);
         upd_pc1     = 32'h2000 + 32'(i * 4);
         upd_target0 = $urandom;
         upd_target1 = $urandom;
         upd_taken   = 2'($urandom);
         step();
      end
      upd_valid = '0;
      repeat (6) step();

      // Single push with the minimum-latency write
      push1(0, 32'h40, 32'h80, 1'b1);
      repeat (4) step();
      chk("single_pc_w", 96'({pc_w, target_w, taken_w}), 96'({32'h40, 32'h80, 1'b1}));

      // Random traffic with occasional invalidate requests
      for (int i = 0; i < 400; i++) begin
         upd_valid   = 2'($urandom);
         upd_pc0     = $urandom;
         upd_pc1     = $urandom;
         upd_target0 = $urandom;
         upd_target1 = $urandom;
         upd_taken   = 2'($urandom);
         inval_req   = ($urandom_range(0, 39) == 0);
         step();
      end
      upd_valid = '0;
      inval_req = 1'b0;
      repeat (20) step();

`ifdef BTB_INVAL_EN
      // Three queued updates followed by an invalidate pulse
      upd_valid = 2'b11;
      upd_pc0 = 32'hA0; upd_pc1 = 32'hB0;
      step();
      upd_valid = 2'b01;
      upd_pc0 = 32'hA4;
      inval_req = 1'b1;
      step();
      upd_valid = '0;
      inval_req = 1'b0;
      repeat (12) step();
      chk("post_sweep_ready", 96'(upd_ready), 96'(2'b11));
      chk("post_sweep_busy", 96'(busy), 96'(0));

      // Reset in the middle of a sweep
      push1(1, 32'hC0, 32'hC8, 1'b0);
      inval_req = 1'b1;
      step();
      inval_req = 1'b0;
      for (int k = 0; k < 40 && !(inv_en && (inv_idx == 2'd2)); k++) step();
      chk("sweep_reached_idx2", 96'(inv_en && (inv_idx == 2'd2)), 96'(1));
`else
      // Reset in the middle of traffic
      upd_valid = 2'b11;
      step();
      upd_valid = '0;
`endif
      nRST = 1'b0;
      #1;
      chk("arst_wen", 96'(WEN), 96'(0));
      chk("arst_payload", 96'({pc_w, target_w, taken_w}), 96'(0));
      chk("arst_inv_en", 96'(inv_en), 96'(0));
      chk("arst_inv_idx", 96'(inv_idx), 96'(0));
      chk("arst_busy", 96'(busy), 96'(0));
      chk("arst_ready", 96'(upd_ready), 96'(0));
      repeat (2) step();
      nRST = 1'b1;
      push1(0, 32'h1234, 32'h5678, 1'b1);
      repeat (4) step();
      chk("post_rst_write", 96'({pc_w, target_w, taken_w}), 96'({32'h1234, 32'h5678, 1'b1}));

      repeat (5) step();
      chk("scoreboard_empty", 96'(expq.size()), 96'(0));
      chk("model_queues_empty", 96'(mq0.size() + mq1.size()), 96'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
